// File: rtl/fll_boot_seq.sv
// FLL bring-up sequencer: programs the FLL over a four-phase config bus, verifies
// a readback, waits for a stable lock, then hands the clock mux over to the FLL.
module fll_boot_seq #(
  parameter logic [31:0] CFG1_VAL     = 32'h0000_0000,
  parameter logic [31:0] CFG2_VAL     = 32'h0000_0000,
  parameter logic [31:0] CFG3_VAL     = 32'h0000_0000,
  parameter int          LOCK_TIMEOUT = 4096,
  parameter int          LOCK_STABLE  = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        bypass_i,
  input  logic        restart_i,
  output logic        fll_req_o,
  output logic        fll_wrn_o,
  output logic [1:0]  fll_add_o,
  output logic [31:0] fll_data_o,
  input  logic        fll_ack_i,
  input  logic [31:0] fll_r_data_i,
  input  logic        fll_lock_i,
  output logic        clk_sel_o,
  output logic        done_o,
  output logic        error_o,
  output logic        lock_lost_o
);
  localparam int TW = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = (LOCK_STABLE  < 1) ? 1 : $clog2(LOCK_STABLE + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] ST_MAX = SW'(LOCK_STABLE);
  localparam bit ST_ONE = (LOCK_STABLE <= 1);

  typedef enum logic [3:0] {
    IDLE, WR1, WR2, WR3, RD1, WAIT_LOCK, STABLE, DONE, ERR
  } state_e;

  state_e        state_q;
  logic          ph_q;        // 0: req phase, 1: waiting for ack to drop
  logic          lk_meta_q, lk_q;
  logic [TW-1:0] to_q;
  logic [SW-1:0] st_q;
  logic [31:0]   rdata_q;
  logic          req_q, wrn_q, clk_sel_q, done_q, err_q, lost_q;
  logic [1:0]    add_q;
  logic [31:0]   data_q;

  logic [TW-1:0] to_inc;
  logic [SW-1:0] st_inc;
  logic          to_hit, st_hit;

  assign to_inc = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
  assign st_inc = (st_q == ST_MAX) ? st_q : st_q + 1'b1;
  assign to_hit = (to_inc >= TO_MAX);
  assign st_hit = (st_inc >= ST_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ph_q      <= 1'b0;
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
      to_q      <= '0;
      st_q      <= '0;
      rdata_q   <= '0;
      req_q     <= 1'b0;
      wrn_q     <= 1'b0;
      add_q     <= '0;
      data_q    <= '0;
      clk_sel_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      lk_meta_q <= fll_lock_i;
      lk_q      <= lk_meta_q;
      case (state_q)
        IDLE: begin
          to_q <= '0;
          st_q <= '0;
          ph_q <= 1'b0;
          if (bypass_i) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            clk_sel_q <= 1'b0;
          end else begin
            state_q <= WR1;
            req_q   <= 1'b1;
            wrn_q   <= 1'b0;
            add_q   <= 2'd1;
            data_q  <= CFG1_VAL;
          end
        end
        WR1, WR2, WR3, RD1: begin
          if (!ph_q) begin
            if (fll_ack_i) begin
              req_q <= 1'b0;
              ph_q  <= 1'b1;
              if (state_q == RD1) rdata_q <= fll_r_data_i;
            end
          end else if (!fll_ack_i) begin
            // ack has returned low: launch the next access in the same edge
            ph_q <= 1'b0;
            case (state_q)
              WR1: begin
                state_q <= WR2; req_q <= 1'b1; add_q <= 2'd2; data_q <= CFG2_VAL;
              end
              WR2: begin
                state_q <= WR3; req_q <= 1'b1; add_q <= 2'd3; data_q <= CFG3_VAL;
              end
              WR3: begin
                state_q <= RD1; req_q <= 1'b1; wrn_q <= 1'b1; add_q <= 2'd1; data_q <= '0;
              end
              default: begin
                wrn_q   <= 1'b0;
                add_q   <= '0;
                to_q    <= '0;
                st_q    <= '0;
                err_q   <= (rdata_q != CFG1_VAL);
                state_q <= (rdata_q != CFG1_VAL) ? ERR : WAIT_LOCK;
              end
            endcase
          end
        end
        WAIT_LOCK: begin
          to_q <= to_inc;
          if (to_hit) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (lk_q) begin
            if (ST_ONE) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              clk_sel_q <= 1'b1;
            end else begin
              state_q <= STABLE;
              st_q    <= SW'(1);
            end
          end
        end
        STABLE: begin
          to_q <= to_inc;
          if (to_hit) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (!lk_q) begin
            state_q <= WAIT_LOCK;
            st_q    <= '0;
          end else begin
            st_q <= st_inc;
            if (st_hit) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              clk_sel_q <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          if (restart_i) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            lost_q    <= 1'b0;
            clk_sel_q <= 1'b0;
            to_q      <= '0;
            st_q      <= '0;
          end else if (state_q == DONE && clk_sel_q && !lk_q) begin
            lost_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fll_req_o   = req_q;
  assign fll_wrn_o   = wrn_q;
  assign fll_add_o   = add_q;
  assign fll_data_o  = data_q;
  assign clk_sel_o   = clk_sel_q;
  assign done_o      = done_q;
  assign error_o     = err_q;
  assign lock_lost_o = lost_q;
endmodule
